// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - memory-mapped PWM duty registers and microsecond/millisecond timers
//
// Purpose: single-cycle-latency MMIO slave at 0xFFFFFFF4..0xFFFFFFFF.
//   0xFFFFFFFC : byte lanes 0..3 = led/red/green/blue PWM duty (R/W)
//   0xFFFFFFF8 : millis (RO)
//   0xFFFFFFF4 : micros (RO)
// Optional feature: define MMIO_TIMERS_EN to build the micros/millis counters;
// without it, timer loads return 0 with a normal ack.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-low reset
//   dmem_req       one-cycle access strobe
//   dmem_wren      1 = store, 0 = load
//   funct3         RV32I size/sign code
//   dmem_address   byte address
//   dmem_data_in   store data, right-aligned
//   dmem_hit       combinational address decode
//   dmem_ack       response strobe, one cycle after an accepted access
//   dmem_data_out  load data, right-aligned and extended (0 when no ack)
//   led/red/green/blue  PWM outputs, high = on
module mmio_responder #(
  parameter int CLK_PER_US = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_req,
  input  logic        dmem_wren,
  input  logic [2:0]  funct3,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  output logic        dmem_hit,
  output logic        dmem_ack,
  output logic [31:0] dmem_data_out,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  if (CLK_PER_US < 1) begin : g_bad_cfg
    $error("mmio_responder: CLK_PER_US must be at least 1");
  end

  logic [7:0]  duty [4];
  logic [7:0]  pwm_cnt;
  logic [31:0] micros;
  logic [31:0] millis;

  // 0xFFFFFFF0..F3 is not ours, so word index 0 is excluded
  assign dmem_hit = (dmem_address[31:4] == 28'hFFFFFFF) && (dmem_address[3:2] != 2'b00);

  logic accept;
  assign accept = dmem_req && dmem_hit;

  logic [31:0] word_rd;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic        aligned;
  logic        size_ok;

  always_comb begin
    word_rd = '0;
    case (dmem_address[3:2])
      2'b11:   word_rd = {duty[3], duty[2], duty[1], duty[0]};
      2'b10:   word_rd = millis;
      2'b01:   word_rd = micros;
      default: word_rd = '0;
    endcase
  end

  assign shifted = word_rd >> {dmem_address[1:0], 3'b000};

  // Alignment is judged on the size bits of funct3 only, so it serves loads and stores alike
  always_comb begin
    aligned = 1'b0;
    size_ok = 1'b1;
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~dmem_address[0];
      2'b10:   aligned = (dmem_address[1:0] == 2'b00);
      default: size_ok = 1'b0;
    endcase
  end

  always_comb begin
    load_val = '0;
    if (aligned && size_ok) begin
      case (funct3)
        3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
        3'b100:  load_val = {24'h0, shifted[7:0]};
        3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
        3'b101:  load_val = {16'h0, shifted[15:0]};
        3'b010:  load_val = shifted;
        default: load_val = '0;
      endcase
    end
  end

  logic store_duty;
  assign store_duty = accept && dmem_wren && (dmem_address[3:2] == 2'b11) &&
                      aligned && size_ok && !funct3[2];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) duty[i] <= '0;
      pwm_cnt       <= '0;
      dmem_ack      <= 1'b0;
      dmem_data_out <= '0;
    end else begin
      pwm_cnt       <= pwm_cnt + 8'd1;
      dmem_ack      <= accept;
      dmem_data_out <= (accept && !dmem_wren) ? load_val : '0;
      if (store_duty) begin
        case (funct3[1:0])
          2'b00: duty[dmem_address[1:0]] <= dmem_data_in[7:0];
          2'b01: begin
            duty[{dmem_address[1], 1'b0}] <= dmem_data_in[7:0];
            duty[{dmem_address[1], 1'b1}] <= dmem_data_in[15:8];
          end
          default: begin
            duty[0] <= dmem_data_in[7:0];
            duty[1] <= dmem_data_in[15:8];
            duty[2] <= dmem_data_in[23:16];
            duty[3] <= dmem_data_in[31:24];
          end
        endcase
      end
    end
  end

  assign led   = pwm_cnt < duty[0];
  assign red   = pwm_cnt < duty[1];
  assign green = pwm_cnt < duty[2];
  assign blue  = pwm_cnt < duty[3];

`ifdef MMIO_TIMERS_EN
  localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [PRE_W-1:0] us_pre;
  logic [9:0]       ms_pre;

  // Loads sample micros/millis before this block updates them, giving the pre-increment value
  always_ff @(posedge clk) begin
    if (!reset) begin
      us_pre <= '0;
      ms_pre <= '0;
      micros <= '0;
      millis <= '0;
    end else if (us_pre == PRE_W'(CLK_PER_US - 1)) begin
      us_pre <= '0;
      micros <= micros + 32'd1;
      if (ms_pre == 10'd999) begin
        ms_pre <= '0;
        millis <= millis + 32'd1;
      end else begin
        ms_pre <= ms_pre + 10'd1;
      end
    end else begin
      us_pre <= us_pre + PRE_W'(1);
    end
  end
`else
  assign micros = '0;
  assign millis = '0;
`endif

endmodule
